// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite read arbiter.
// Holds the FSM encoding, the RRESP codes and the timeout-timer width helper.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StResp,
    StRespTo,
    StDrain
  } arb_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  // Wide enough to hold the value TIMEOUT_CYCLES itself.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/axil_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr_i,
// wrapping modulo NUM_REQ. Returns the grant both one-hot and as an index.
module axil_read_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read master among NUM_REQ clients.
// One AR/R transaction at a time, with an R-channel timeout and post-timeout drain.
module axil_read_arbiter
  import axil_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                                  M_AXI_ACLK,
  input  logic                                  M_AXI_ARESET,
  input  logic [NUM_REQ-1:0]                    REQ_VALID,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
  output logic [NUM_REQ-1:0]                    REQ_READY,
  output logic [NUM_REQ-1:0]                    RSP_VALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         RSP_DATA,
  output logic                                  RSP_ERR,
  output logic                                  BUSY,
  output logic                                  M_AXI_ARVALID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  input  logic                                  M_AXI_ARREADY,
  input  logic                                  M_AXI_RVALID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                            M_AXI_RRESP,
  output logic                                  M_AXI_RREADY
);

  localparam int unsigned AW     = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW     = C_M_AXI_DATA_WIDTH;
  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned TimerW = timer_width(TIMEOUT_CYCLES);

  arb_state_e         state_q, state_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]    gnt_q, gnt_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               arvalid_q, arvalid_d;
  logic [AW-1:0]      araddr_q, araddr_d;
  logic               rready_q, rready_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic [AW-1:0]      sel_addr;
  logic [TimerW-1:0]  timer_inc;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IdxW-1:0]    next_ptr;

  axil_read_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_pick (
    .req_i (REQ_VALID),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign sel_addr   = REQ_ADDR[32'(pick_idx) * AW +: AW];
  assign timer_inc  = timer_q + TimerW'(1);
  assign gnt_onehot = NUM_REQ'(1) << gnt_q;
  assign next_ptr   = IdxW'((32'(gnt_q) + 32'd1) % NUM_REQ);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    timer_d     = timer_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    rready_d    = rready_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (|REQ_VALID) begin
          gnt_d       = pick_idx;
          araddr_d    = sel_addr & ~AW'(3);
          arvalid_d   = 1'b1;
          req_ready_d = pick_gnt;
          state_d     = StAddr;
        end
      end
      StAddr: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          timer_d   = '0;
          state_d   = StData;
        end
      end
      StData: begin
        timer_d = timer_inc;
        // A beat arriving on the timeout cycle still counts as a normal response.
        if (M_AXI_RVALID) begin
          rsp_data_d  = M_AXI_RDATA;
          rsp_err_d   = (M_AXI_RRESP == RespSlverr) || (M_AXI_RRESP == RespDecerr);
          rready_d    = 1'b0;
          rsp_valid_d = gnt_onehot;
          state_d     = StResp;
        end else if (timer_inc == TimerW'(TIMEOUT_CYCLES)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_onehot;
          state_d     = StRespTo;
        end
      end
      StResp: begin
        rr_ptr_d = next_ptr;
        state_d  = StIdle;
      end
      StRespTo: begin
        rr_ptr_d = next_ptr;
        // RREADY is already high here, so a beat now completes the drain.
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          state_d  = StIdle;
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      timer_q     <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      timer_q     <= timer_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign REQ_READY     = req_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_DATA      = rsp_data_q;
  assign RSP_ERR       = rsp_err_q;
  assign BUSY          = busy_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axil_read_arbiter.md
Name: axil_read_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Lite read master port among NUM_REQ internal requesters.
- Requesters are simple register-read clients, such as pitch-detector status pollers and display readers.
- Sequences one full AR/R transaction at a time and routes the returned data back to the granted requester.
- Adds an R-channel timeout, so a hung peripheral reports an error instead of stalling the requester indefinitely.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 256, max cycles waiting for RVALID after AR handshake (>=2)

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESET  in  1  reset, asynchronous, active-high
- REQ_VALID  in  NUM_REQ  per-requester read request
- REQ_ADDR  in  NUM_REQ*C_M_AXI_ADDR_WIDTH  packed addresses, requester i at slice i
- REQ_READY  out  NUM_REQ  one-hot, one-cycle request-accepted pulse
- RSP_VALID  out  NUM_REQ  one-hot, one-cycle response pulse
- RSP_DATA  out  C_M_AXI_DATA_WIDTH  response data, shared by all requesters
- RSP_ERR  out  1  response error flag, qualified by RSP_VALID
- BUSY  out  1  high whenever the FSM is not in IDLE
- M_AXI_ARVALID  out  1  AR channel valid
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  AR channel address
- M_AXI_ARREADY  in  1  AR channel ready
- M_AXI_RVALID  in  1  R channel valid
- M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  R channel data
- M_AXI_RRESP  in  2  R channel response
- M_AXI_RREADY  out  1  R channel ready

Behaviour:
- Reset: M_AXI_ARESET asserted clears immediately, without a clock edge:
  - state = IDLE, rr_ptr = 0, timer = 0
  - all outputs 0, including ARADDR, RSP_DATA and RSP_ERR
  - Reset mid-transaction abandons the transaction; the downstream slave shares this reset.
- All outputs are registered.
- IDLE:
  - If any REQ_VALID is high, grant g is the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - At the clock edge: latch g; ARADDR <= REQ_ADDR[g] with bits [1:0] forced to 0; ARVALID <= 1; REQ_READY[g] <= 1 for exactly one cycle; go to ADDR.
  - No request: stay in IDLE.
- ADDR:
  - ARVALID and ARADDR are held stable until ARREADY is high.
  - On handshake: ARVALID <= 0, RREADY <= 1, timer <= 0, go to DATA.
  - No timeout in ADDR; AXI forbids withdrawing ARVALID.
- DATA:
  - timer increments every cycle.
  - On RVALID: capture RDATA into RSP_DATA; RSP_ERR <= RRESP[1]; RREADY <= 0; go to RESP.
  - Timer reaches TIMEOUT_CYCLES without RVALID: RSP_DATA <= 0, RSP_ERR <= 1, go to RESP_TO.
  - RVALID arriving on the same cycle as the timeout: RVALID wins and the response is normal.
- RESP: RSP_VALID[g] = 1 for one cycle; rr_ptr <= (g+1) mod NUM_REQ; go to IDLE.
- RESP_TO: RSP_VALID[g] = 1 for one cycle; rr_ptr is advanced as in RESP; RREADY stays 1; go to DRAIN.
- DRAIN: RREADY = 1; on RVALID, discard the beat, RREADY <= 0, go to IDLE. No new arbitration occurs until the drain completes.
- Requester contract:
  - Hold REQ_VALID and REQ_ADDR until REQ_READY is seen, then deassert REQ_VALID.
  - Deassert before grant is legal: the request is simply not granted.
  - A REQ_VALID still high in the REQ_READY cycle is ignored, because the FSM is not in IDLE.
- Only one transaction is outstanding; no AR pipelining.
- Minimum latency, with ARREADY already high and RVALID one cycle after the AR handshake:
  - request sampled in IDLE at cycle t0
  - ARVALID/REQ_READY at t0+1
  - RVALID accepted at t0+2
  - RSP_VALID at t0+3
- RRESP mapping: OKAY/EXOKAY -> RSP_ERR = 0; SLVERR/DECERR -> RSP_ERR = 1.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transactions.

Decomposition:
- Shared package axil_arb_pkg:
  - FSM state encoding: IDLE, ADDR, DATA, RESP, RESP_TO, DRAIN
  - RRESP constants: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11
  - Timer width: clog2(TIMEOUT_CYCLES+1)
- Sub-module rr_pick: combinational; inputs req vector and rr_ptr; outputs one-hot grant and index.

Test Plan:
- Single requester 1, ADDR=0x43C0_0006, slave returns 0xDEADBEEF/OKAY with ARREADY high and RVALID one cycle after the AR handshake -> ARADDR=0x43C0_0004; REQ_READY[1] at t0+1; RSP_VALID=4'b0010 at t0+3; RSP_DATA=0xDEADBEEF; RSP_ERR=0.
- All 4 requesting continuously from reset -> grant order 0,1,2,3,0; each RSP_VALID is one-hot and matches the address slice.
- ARREADY held low 5 cycles -> ARVALID/ARADDR stable for all 6 cycles; no timeout; normal response.
- Slave never drives RVALID, TIMEOUT_CYCLES=8 -> RSP_ERR=1 and RSP_DATA=0 after 8 DATA cycles. Late RVALID 3 cycles later is drained; the next request is granted only after the drain.
- Slave returns RRESP=2'b10 -> RSP_ERR=1 and RSP_DATA carries RDATA. RVALID on exact timeout cycle -> normal (non-error) response.
- M_AXI_ARESET pulsed mid-DATA -> all outputs 0 asynchronously, before the next edge; after release, first grant goes to requester 0.
